l2_bank_tcdm_adapter: RTL and testbench



---
 rtl/l2_bank_tcdm_adapter.sv | 144 ++++++++++++++
 tb/tb_l2_bank_tcdm_adapter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_bank_tcdm_adapter.sv
// TCDM slave to single-port SRAM adapter for one L2 bank port.
// One-entry skid absorbs SRAM stalls; responses return in order through a fixed-latency pipe.
module l2_bank_tcdm_adapter #(
  parameter int unsigned              ADDR_WIDTH      = 32,
  parameter int unsigned              DATA_WIDTH      = 32,
  parameter int unsigned              MEM_ADDR_WIDTH  = 12,
  parameter int unsigned              MEM_ADDR_LSB    = 2,
  parameter logic [ADDR_WIDTH-1:0]    BANK_BASE_ADDR  = 32'h1C00_0000,
  parameter logic [ADDR_WIDTH-1:0]    BANK_SIZE_BYTES = 32'h0000_4000,
  parameter int unsigned              SRAM_LATENCY    = 1,
  parameter logic [DATA_WIDTH-1:0]    ERR_RDATA       = 32'hBADA_CCE5
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        tcdm_req_i,
  output logic                        tcdm_gnt_o,
  input  logic [ADDR_WIDTH-1:0]       tcdm_add_i,
  input  logic                        tcdm_wen_i,
  input  logic [DATA_WIDTH-1:0]       tcdm_wdata_i,
  input  logic [DATA_WIDTH/8-1:0]     tcdm_be_i,
  output logic                        tcdm_r_valid_o,
  output logic [DATA_WIDTH-1:0]       tcdm_r_rdata_o,
  output logic                        tcdm_r_opc_o,
  output logic                        mem_req_o,
  input  logic                        mem_ready_i,
  output logic                        mem_we_o,
  output logic [MEM_ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]       mem_wdata_o,
  output logic [DATA_WIDTH/8-1:0]     mem_be_o,
  input  logic [DATA_WIDTH-1:0]       mem_rdata_i
);

  localparam int unsigned BeWidth = DATA_WIDTH / 8;
  localparam int unsigned Head    = SRAM_LATENCY - 1;

  // Skid register
  logic                      r_skid_full;
  logic                      r_skid_we;
  logic [MEM_ADDR_WIDTH-1:0] r_skid_addr;
  logic [DATA_WIDTH-1:0]     r_skid_wdata;
  logic [BeWidth-1:0]        r_skid_be;

  // Response pipe, one bit per stage for valid / error / read
  logic [SRAM_LATENCY-1:0]   r_pipe_valid;
  logic [SRAM_LATENCY-1:0]   r_pipe_err;
  logic [SRAM_LATENCY-1:0]   r_pipe_read;

  logic [ADDR_WIDTH-1:0]     w_offset;
  logic                      w_in_range;
  logic                      w_accept;
  logic                      w_acc_mem;
  logic                      w_acc_err;
  logic                      w_in_we;
  logic [MEM_ADDR_WIDTH-1:0] w_in_addr;
  logic [BeWidth-1:0]        w_in_be;
  logic                      w_issue;
  logic                      w_capture;
  logic                      w_push_valid;
  logic                      w_push_err;
  logic                      w_push_read;

  // Wrapping subtraction makes addresses below the base fall out of range.
  assign w_offset   = tcdm_add_i - BANK_BASE_ADDR;
  assign w_in_range = (w_offset < BANK_SIZE_BYTES);
  assign w_in_addr  = w_offset[MEM_ADDR_LSB +: MEM_ADDR_WIDTH];
  assign w_in_we    = ~tcdm_wen_i;
  assign w_in_be    = tcdm_wen_i ? {BeWidth{1'b1}} : tcdm_be_i;

  // A full skid blocks all new requests, including errors, to keep response order.
  assign tcdm_gnt_o = ~r_skid_full;
  assign w_accept   = tcdm_req_i & ~r_skid_full;
  assign w_acc_mem  = w_accept & w_in_range;
  assign w_acc_err  = w_accept & ~w_in_range;

  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_be_o    = '0;
    if (r_skid_full) begin
      mem_req_o   = 1'b1;
      mem_we_o    = r_skid_we;
      mem_addr_o  = r_skid_addr;
      mem_wdata_o = r_skid_wdata;
      mem_be_o    = r_skid_be;
    end else begin
      mem_req_o   = w_acc_mem;
      mem_we_o    = w_in_we;
      mem_addr_o  = w_in_addr;
      mem_wdata_o = tcdm_wdata_i;
      mem_be_o    = w_in_be;
    end
  end

  assign w_issue      = mem_req_o & mem_ready_i;
  assign w_capture    = w_acc_mem & ~mem_ready_i;
  assign w_push_valid = w_issue | w_acc_err;
  assign w_push_err   = w_acc_err;
  assign w_push_read  = w_issue & ~mem_we_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_skid_full <= 1'b0;
    end else if (w_capture) begin
      r_skid_full <= 1'b1;
    end else if (r_skid_full && mem_ready_i) begin
      r_skid_full <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_capture) begin
      r_skid_we    <= w_in_we;
      r_skid_addr  <= w_in_addr;
      r_skid_wdata <= tcdm_wdata_i;
      r_skid_be    <= w_in_be;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pipe_valid <= '0;
      r_pipe_err   <= '0;
      r_pipe_read  <= '0;
    end else begin
      r_pipe_valid[0] <= w_push_valid;
      r_pipe_err[0]   <= w_push_err;
      r_pipe_read[0]  <= w_push_read;
      for (int unsigned i = 1; i < SRAM_LATENCY; i++) begin
        r_pipe_valid[i] <= r_pipe_valid[i-1];
        r_pipe_err[i]   <= r_pipe_err[i-1];
        r_pipe_read[i]  <= r_pipe_read[i-1];
      end
    end
  end

  // Idle stages carry err=0/read=0, so rdata reads as zero whenever no response is valid.
  assign tcdm_r_valid_o = r_pipe_valid[Head];
  assign tcdm_r_opc_o   = r_pipe_err[Head];
  assign tcdm_r_rdata_o = r_pipe_err[Head]  ? ERR_RDATA   :
                          r_pipe_read[Head] ? mem_rdata_i : '0;

endmodule

// File: tb/tb_l2_bank_tcdm_adapter.sv
// Self-checking bench: SRAM environment plus a transaction-level reference of the adapter.
module tb_l2_bank_tcdm_adapter;

  localparam int unsigned Lat     = 2;
  localparam logic [31:0] Base    = 32'h1C00_0000;
  localparam logic [31:0] Size    = 32'h0000_4000;
  localparam logic [31:0] ErrData = 32'hBADA_CCE5;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        tcdm_req_i;
  logic        tcdm_gnt_o;
  logic [31:0] tcdm_add_i;
  logic        tcdm_wen_i;
  logic [31:0] tcdm_wdata_i;
  logic [3:0]  tcdm_be_i;
  logic        tcdm_r_valid_o;
  logic [31:0] tcdm_r_rdata_o;
  logic        tcdm_r_opc_o;
  logic        mem_req_o;
  logic        mem_ready_i;
  logic        mem_we_o;
  logic [11:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_rdata_i;

  l2_bank_tcdm_adapter #(
    .ADDR_WIDTH     (32),
    .DATA_WIDTH     (32),
    .MEM_ADDR_WIDTH (12),
    .MEM_ADDR_LSB   (2),
    .BANK_BASE_ADDR (Base),
    .BANK_SIZE_BYTES(Size),
    .SRAM_LATENCY   (Lat),
    .ERR_RDATA      (ErrData)
  ) u_dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .tcdm_req_i    (tcdm_req_i),
    .tcdm_gnt_o    (tcdm_gnt_o),
    .tcdm_add_i    (tcdm_add_i),
    .tcdm_wen_i    (tcdm_wen_i),
    .tcdm_wdata_i  (tcdm_wdata_i),
    .tcdm_be_i     (tcdm_be_i),
    .tcdm_r_valid_o(tcdm_r_valid_o),
    .tcdm_r_rdata_o(tcdm_r_rdata_o),
    .tcdm_r_opc_o  (tcdm_r_opc_o),
    .mem_req_o     (mem_req_o),
    .mem_ready_i   (mem_ready_i),
    .mem_we_o      (mem_we_o),
    .mem_addr_o    (mem_addr_o),
    .mem_wdata_o   (mem_wdata_o),
    .mem_be_o      (mem_be_o),
    .mem_rdata_i   (mem_rdata_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] data;
    logic        opc;
  } resp_t;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int          cyc      = 0;
  logic [31:0] sram_mem [4096];
  logic [31:0] ref_mem  [4096];
  logic [31:0] rd_at    [int];
  resp_t       resp_q   [$];
  bit          pend;
  logic        pend_we;
  logic [11:0] pend_addr;
  logic [31:0] pend_wdata;
  logic [3:0]  pend_be;
  bit          last_grant;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // Runs at the negedge: SRAM environment first, then the reference model and checks.
  task automatic evaluate();
    logic [31:0] off;
    logic [11:0] waddr;
    bit          in_range;
    bit          exp_gnt;
    bit          exp_rv;
    bit          exp_mreq;
    resp_t       r;
    if (mem_req_o === 1'b1 && mem_ready_i) begin
      if (mem_we_o) sram_mem[mem_addr_o] = merge(sram_mem[mem_addr_o], mem_wdata_o, mem_be_o);
      else rd_at[cyc + Lat] = sram_mem[mem_addr_o];
    end
    last_grant = 1'b0;
    if (rst_i) begin
      resp_q.delete();
      pend = 1'b0;
      return;
    end
    off      = tcdm_add_i - Base;
    in_range = off < Size;
    waddr    = off[13:2];
    exp_gnt  = !pend;
    exp_rv   = resp_q.size() > 0 && resp_q[0].due == cyc;
    check_eq("gnt", 32'(tcdm_gnt_o), 32'(exp_gnt));
    check_eq("r_valid", 32'(tcdm_r_valid_o), 32'(exp_rv));
    if (exp_rv) begin
      check_eq("r_rdata", tcdm_r_rdata_o, resp_q[0].data);
      check_eq("r_opc", 32'(tcdm_r_opc_o), 32'(resp_q[0].opc));
      void'(resp_q.pop_front());
    end
    exp_mreq = pend || (tcdm_req_i && in_range && exp_gnt);
    check_eq("mem_req", 32'(mem_req_o), 32'(exp_mreq));
    if (exp_mreq) begin
      if (pend) begin
        check_eq("mem_addr_skid", 32'(mem_addr_o), 32'(pend_addr));
        check_eq("mem_we_skid", 32'(mem_we_o), 32'(pend_we));
        check_eq("mem_be_skid", 32'(mem_be_o), 32'(pend_be));
        if (pend_we) check_eq("mem_wdata_skid", mem_wdata_o, pend_wdata);
      end else begin
        check_eq("mem_addr", 32'(mem_addr_o), 32'(waddr));
        check_eq("mem_we", 32'(mem_we_o), 32'(!tcdm_wen_i));
        check_eq("mem_be", 32'(mem_be_o), tcdm_wen_i ? 32'hF : 32'(tcdm_be_i));
        if (!tcdm_wen_i) check_eq("mem_wdata", mem_wdata_o, tcdm_wdata_i);
      end
    end
    if (tcdm_req_i && exp_gnt) begin
      last_grant = 1'b1;
      r.due = -1;
      if (!in_range) begin
        r.data = ErrData;
        r.opc  = 1'b1;
        r.due  = cyc + Lat;
      end else begin
        r.opc = 1'b0;
        if (tcdm_wen_i) begin
          r.data = ref_mem[waddr];
        end else begin
          r.data = 32'h0;
          ref_mem[waddr] = merge(ref_mem[waddr], tcdm_wdata_i, tcdm_be_i);
        end
        if (mem_ready_i) begin
          r.due = cyc + Lat;
        end else begin
          pend       = 1'b1;
          pend_we    = !tcdm_wen_i;
          pend_addr  = waddr;
          pend_wdata = tcdm_wdata_i;
          pend_be    = tcdm_wen_i ? 4'hF : tcdm_be_i;
        end
      end
      resp_q.push_back(r);
    end else if (pend && mem_ready_i) begin
      // A stalled access completes the first cycle the SRAM is ready.
      resp_q[resp_q.size()-1].due = cyc + Lat;
      pend = 1'b0;
    end
  endtask

  task automatic step(input bit req, input logic [31:0] add, input bit wen,
                      input logic [31:0] wdata, input logic [3:0] be, input bit rdy,
                      input bit rst);
    @(posedge clk);
    #1;
    cyc++;
    rst_i        = rst;
    tcdm_req_i   = req;
    tcdm_add_i   = add;
    tcdm_wen_i   = wen;
    tcdm_wdata_i = wdata;
    tcdm_be_i    = be;
    mem_ready_i  = rdy;
    mem_rdata_i  = rd_at.exists(cyc) ? rd_at[cyc] : $urandom();
    @(negedge clk);
    evaluate();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b1, 32'h0, 4'h0, 1'b1, 1'b0);
  endtask

  task automatic rd(input logic [31:0] add, input bit rdy);
    step(1'b1, add, 1'b1, $urandom(), 4'h0, rdy, 1'b0);
  endtask

  logic [31:0] cur_add;
  logic [31:0] cur_wdata;
  logic [3:0]  cur_be;
  bit          cur_req;
  bit          cur_wen;
  int          sel;

  initial begin
    for (int i = 0; i < 4096; i++) begin
      sram_mem[i] = $urandom();
      ref_mem[i]  = sram_mem[i];
    end
    rst_i = 1'b1; tcdm_req_i = 1'b0; tcdm_add_i = '0; tcdm_wen_i = 1'b1;
    tcdm_wdata_i = '0; tcdm_be_i = '0; mem_ready_i = 1'b1; mem_rdata_i = '0;
    pend = 1'b0;
    step(1'b0, 32'h0, 1'b1, 32'h0, 4'h0, 1'b1, 1'b1);
    step(1'b0, 32'h0, 1'b1, 32'h0, 4'h0, 1'b1, 1'b1);
    idle(1);
    check_eq("rst_rdata", tcdm_r_rdata_o, 32'h0);
    check_eq("rst_opc", 32'(tcdm_r_opc_o), 32'h0);

    // Back-to-back reads
    for (int i = 0; i < 4; i++) rd(Base + 32'(4 * i), 1'b1);
    idle(Lat + 1);

    // Partial write then read back
    step(1'b1, Base + 32'h10, 1'b0, 32'hDEAD_BEEF, 4'b0101, 1'b1, 1'b0);
    rd(Base + 32'h10, 1'b1);
    idle(Lat + 1);
    check_eq("merged_ref", ref_mem[4], merge(sram_mem[4], 32'h0, 4'h0));

    // Read burst with three stalled cycles; the master holds each request until granted
    rd(Base + 32'h20, 1'b0);
    rd(Base + 32'h24, 1'b0);
    rd(Base + 32'h24, 1'b0);
    rd(Base + 32'h24, 1'b1);
    rd(Base + 32'h24, 1'b1);
    rd(Base + 32'h28, 1'b1);
    idle(Lat + 1);

    // Out-of-range reads
    rd(Base + Size, 1'b1);
    rd(Base - 32'h4, 1'b1);
    idle(Lat + 1);

    // In-range stalled, then error, then in-range
    rd(Base + 32'h30, 1'b0);
    rd(Base + Size + 32'h100, 1'b0);
    rd(Base + Size + 32'h100, 1'b1);
    rd(Base + Size + 32'h100, 1'b1);
    rd(Base + 32'h34, 1'b1);
    idle(Lat + 1);

    // Reset with two responses in flight and a request being captured into the skid
    rd(Base + 32'h40, 1'b1);
    rd(Base + 32'h44, 1'b1);
    step(1'b1, Base + 32'h48, 1'b1, 32'h0, 4'h0, 1'b0, 1'b1);
    idle(Lat + 3);

    // Randomized traffic with held requests
    cur_req = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (!cur_req || last_grant) begin
        cur_req   = ($urandom_range(0, 3) != 0);
        sel       = $urandom_range(0, 9);
        cur_add   = (sel == 0) ? Base + Size :
                    (sel == 1) ? Base - 32'h4 :
                    (sel == 2) ? $urandom() :
                    Base + (32'($urandom_range(0, 63)) << 2) + 32'($urandom_range(0, 3));
        cur_wen   = $urandom_range(0, 1) == 1;
        cur_wdata = $urandom();
        cur_be    = 4'($urandom_range(0, 15));
      end
      step(cur_req, cur_add, cur_wen, cur_wdata, cur_be, $urandom_range(0, 2) != 0, 1'b0);
    end
    idle(Lat + 6);
    check_eq("drain_resp_q", 32'(resp_q.size()), 32'h0);
    check_eq("drain_pending", 32'(pend), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
